conv_bias_relu_stage: RTL and testbench

Downstream consumer of the conv-layer bias buffer. After the buffer reports its bias load complete, this stage requests the 32-channel bias vector once and holds it locally. It then takes per-pixel 32-channel convolution partial sums, adds the bias, rounds, saturates and applies ReLU. Results go to the pooling stage over a valid/ready stream.

---
 rtl/conv_bias_relu_stage.sv | 141 ++++++++++++++
 tb/tb_conv_bias_relu_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_bias_relu_stage.sv
// Bias add, Q16.16 -> Q8.8 round/saturate and ReLU for 32 conv channels.
// Fetches the bias vector once per load/reload and streams results to pooling.
module conv_bias_relu_stage #(
    parameter int CH         = 32,
    parameter int ACC_W      = 32,
    parameter int DW         = 16,
    parameter int FRAC_SHIFT = 8,
    parameter int NUM_PIX    = 576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_conv_bias,
    output logic              bias_r_en,
    input  logic [CH*DW-1:0]  conv_bias,
    input  logic              bias_reload,
    input  logic              psum_valid,
    output logic              psum_ready,
    input  logic [CH*ACC_W-1:0] psum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH*DW-1:0]  out_data,
    output logic              frame_done,
    output logic              bias_loaded
);
    localparam int SW = ACC_W + 2;
    localparam int CW = $clog2(NUM_PIX);

    typedef enum logic [1:0] {IDLE, REQ, LATCH, RUN} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CH*DW-1:0]     bias_q;
    logic                 pending;
    logic                 blocking;
    logic [CW-1:0]        pix;
    logic                 s1_valid;
    logic [CH-1:0][SW-1:0] s1_r;
    logic [CH-1:0][SW-1:0] s1_nxt;
    logic [CH*DW-1:0]     relu_nxt;
    logic                 adv1;
    logic                 adv2;
    logic                 accept;
    logic                 out_xfer;
    logic                 last_pix;
    logic signed [SW-1:0] sum;

    always_comb begin
        adv2       = !out_valid || out_ready;
        adv1       = adv2 || !out_valid;
        psum_ready = (state == RUN) && !blocking && (!s1_valid || adv1);
        accept     = psum_valid && psum_ready;
        out_xfer   = out_valid && out_ready;
        last_pix   = (pix == CW'(NUM_PIX - 1));
        frame_done = out_xfer && last_pix;
    end

    always_comb begin
        state_nxt = state;
        bias_r_en = 1'b0;
        unique case (state)
            IDLE:  if (done_conv_bias) state_nxt = REQ;
            REQ: begin
                bias_r_en = 1'b1;
                state_nxt = LATCH;
            end
            LATCH: state_nxt = RUN;
            RUN: begin
                if (blocking && !s1_valid && !out_valid) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bias_q      <= '0;
            bias_loaded <= 1'b0;
            pending     <= 1'b0;
            blocking    <= 1'b0;
            pix         <= '0;
        end else begin
            state <= state_nxt;
            if (state == LATCH) begin
                bias_q      <= conv_bias;
                bias_loaded <= 1'b1;
                blocking    <= 1'b0;
            end
            // A reload request only matters once the bias is in use.
            if (state != RUN || state_nxt == REQ) begin
                pending <= 1'b0;
            end else if (bias_reload) begin
                pending <= 1'b1;
            end
            if (state == RUN && state_nxt == REQ) bias_loaded <= 1'b0;
            if (state == RUN && frame_done && (pending || bias_reload)) begin
                blocking <= 1'b1;
            end
            if (out_xfer) pix <= last_pix ? '0 : pix + CW'(1);
        end
    end

    always_comb begin
        s1_nxt   = '0;
        relu_nxt = '0;
        sum      = '0;
        for (int i = 0; i < CH; i++) begin
            sum = SW'($signed(psum[i*ACC_W +: ACC_W]))
                + (SW'($signed(bias_q[i*DW +: DW])) <<< FRAC_SHIFT)
                + SW'(1 << (FRAC_SHIFT - 1));
            s1_nxt[i] = SW'(sum >>> FRAC_SHIFT);
            if (s1_r[i][SW-1]) begin
                relu_nxt[i*DW +: DW] = '0;
            end else if (s1_r[i] > SW'((1 << (DW - 1)) - 1)) begin
                relu_nxt[i*DW +: DW] = DW'((1 << (DW - 1)) - 1);
            end else begin
                relu_nxt[i*DW +: DW] = s1_r[i][DW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_r      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_r     <= s1_nxt;
            end else if (adv1) begin
                s1_valid <= 1'b0;
            end
            if (adv2) begin
                out_valid <= s1_valid;
                if (s1_valid) out_data <= relu_nxt;
            end
        end
    end
endmodule

// File: tb/tb_conv_bias_relu_stage.sv
// Directed bench for conv_bias_relu_stage with a scoreboard queue.
// Includes a small bias-buffer responder and a reference arithmetic model.
module tb_conv_bias_relu_stage;
    localparam int CH = 32;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int NP = 576;
    localparam int NOSTALL = 1000000;

    logic clk = 1'b0;
    logic rst;
    logic done_conv_bias;
    logic bias_r_en;
    logic [CH*DW-1:0] conv_bias;
    logic bias_reload;
    logic psum_valid;
    logic psum_ready;
    logic [CH*AW-1:0] psum;
    logic out_valid;
    logic out_ready;
    logic [CH*DW-1:0] out_data;
    logic frame_done;
    logic bias_loaded;

    always #5 clk = ~clk;

    conv_bias_relu_stage dut (
        .clk            (clk),
        .rst            (rst),
        .done_conv_bias (done_conv_bias),
        .bias_r_en      (bias_r_en),
        .conv_bias      (conv_bias),
        .bias_reload    (bias_reload),
        .psum_valid     (psum_valid),
        .psum_ready     (psum_ready),
        .psum           (psum),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .frame_done     (frame_done),
        .bias_loaded    (bias_loaded)
    );

    int n_tests = 0;
    int n_fail = 0;
    int n_req = 0;
    int n_frames = 0;
    int tb_pix = 0;
    logic req_d = 1'b0;
    logic [CH*DW-1:0] sbq[$];
    logic [CH*DW-1:0] bias_src;
    logic [CH*DW-1:0] bias_model;

    task automatic check(string tag, logic [511:0] obs, logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CH*DW-1:0] model(logic [CH*AW-1:0] p,
                                               logic [CH*DW-1:0] b);
        logic [CH*DW-1:0] o;
        longint s;
        longint r;
        o = '0;
        for (int i = 0; i < CH; i++) begin
            s = longint'($signed(p[i*AW +: AW]))
              + 256 * longint'($signed(b[i*DW +: DW])) + 128;
            r = (s >= 0) ? s / 256 : -((-s + 255) / 256);
            if (r < 0) o[i*DW +: DW] = 16'h0000;
            else if (r > 32767) o[i*DW +: DW] = 16'h7FFF;
            else o[i*DW +: DW] = 16'(r);
        end
        return o;
    endfunction

    function automatic logic [CH*AW-1:0] rand_psum();
        logic [CH*AW-1:0] v;
        v = '0;
        for (int i = 0; i < CH; i++) begin
            case ($urandom_range(0, 2))
                0: v[i*AW +: AW] = 32'($urandom);
                1: v[i*AW +: AW] = 32'($urandom_range(0, 24'hFFFFFF));
                default: v[i*AW +: AW] = 32'(-int'($urandom_range(0, 24'hFFFFFF)));
            endcase
        end
        return v;
    endfunction

    function automatic logic [CH*DW-1:0] mkbias(int k);
        logic [CH*DW-1:0] b;
        for (int i = 0; i < CH; i++) b[i*DW +: DW] = 16'(i * 37 * k - 400);
        return b;
    endfunction

    // Bias buffer: data valid only in the cycle after a request.
    always @(negedge clk) begin
        req_d = bias_r_en;
        if (!rst && bias_r_en === 1'b1) n_req++;
    end

    always @(posedge clk) begin
        #1;
        conv_bias = req_d ? bias_src : ~bias_src;
    end

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            tb_pix = 0;
        end else begin
            check("frame_done", frame_done,
                  out_valid && out_ready && tb_pix == NP - 1);
            if (frame_done === 1'b1) n_frames++;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL sb_extra got=%0h want=none", out_data);
                end else begin
                    check("sb_data", out_data, sbq.pop_front());
                end
                tb_pix = (tb_pix == NP - 1) ? 0 : tb_pix + 1;
            end
            if (psum_valid && psum_ready) sbq.push_back(model(psum, bias_model));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(int n, int st, int sl);
        int sent = 0;
        int c = 0;
        logic acc;
        logic [CH*DW-1:0] hold = '0;
        psum = rand_psum();
        psum_valid = 1'b1;
        while (sent < n && c < 5000) begin
            out_ready = !(c >= st && c < st + sl);
            @(negedge clk);
            if (c == st) hold = out_data;
            if (c > st && c < st + sl) begin
                check("bp_hold", out_data, hold);
                check("bp_valid", out_valid, 1);
                check("bp_ready", psum_ready, 0);
            end
            acc = psum_valid && psum_ready;
            tick();
            c++;
            if (acc) begin
                sent++;
                if (sent < n) psum = rand_psum();
            end
        end
        psum_valid = 1'b0;
        out_ready = 1'b1;
        if (c >= 5000) check("feed_timeout", sent, n);
    endtask

    task automatic drain();
        int c = 0;
        while ((sbq.size() != 0 || out_valid) && c < 50) begin
            tick();
            c++;
        end
        check("drain", sbq.size(), 0);
    endtask

    task automatic wait_loaded(string tag);
        int c = 0;
        while (bias_loaded !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        check(tag, bias_loaded, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CH*AW-1:0] p;
        int c;
        logic saw_low;
        rst = 1'b1;
        done_conv_bias = 1'b0;
        bias_reload = 1'b0;
        psum_valid = 1'b0;
        psum = '0;
        out_ready = 1'b1;
        bias_src = mkbias(1);
        bias_src[15:0] = 16'h0100;
        bias_src[31:16] = 16'hFE00;
        bias_src[47:32] = 16'h7F00;
        bias_src[63:48] = 16'h0000;
        bias_model = bias_src;
        repeat (2) tick();
        check("rst_bias_r_en", bias_r_en, 0);
        check("rst_psum_ready", psum_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_bias_loaded", bias_loaded, 0);
        rst = 1'b0;

        repeat (5) tick();
        bias_reload = 1'b1;
        tick();
        bias_reload = 1'b0;
        repeat (4) tick();
        check("idle_no_req", n_req, 0);
        check("idle_loaded", bias_loaded, 0);
        check("idle_ready", psum_ready, 0);
        done_conv_bias = 1'b1;
        tick();
        check("req_pulse", bias_r_en, 1);
        tick();
        check("latch_req_off", bias_r_en, 0);
        check("latch_loaded", bias_loaded, 0);
        check("latch_ready", psum_ready, 0);
        tick();
        check("run_loaded", bias_loaded, 1);
        check("run_ready", psum_ready, 1);
        repeat (3) tick();
        check("one_req", n_req, 1);

        p = rand_psum();
        p[31:0] = 32'h0001_8000;
        p[63:32] = 32'h0001_0000;
        p[95:64] = 32'h0100_0000;
        p[127:96] = 32'h0000_0080;
        psum = p;
        psum_valid = 1'b1;
        tick();
        psum_valid = 1'b0;
        tick();
        check("arith_valid", out_valid, 1);
        check("arith_ch0", out_data[15:0], 16'h0280);
        check("arith_ch1_neg", out_data[31:16], 16'h0000);
        check("arith_ch2_sat", out_data[47:32], 16'h7FFF);
        check("arith_ch3_up", out_data[63:48], 16'h0001);
        p[127:96] = 32'h0000_007F;
        psum = p;
        psum_valid = 1'b1;
        tick();
        psum_valid = 1'b0;
        tick();
        check("arith_ch3_down", out_data[63:48], 16'h0000);
        drain();

        psum_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            psum = rand_psum();
            tick();
            check("stream_valid", out_valid, i >= 1);
        end
        psum_valid = 1'b0;
        tick();
        check("stream_tail", out_valid, 1);
        tick();
        check("stream_end", out_valid, 0);
        drain();

        feed(12, 4, 5);
        drain();
        done_conv_bias = 1'b0;
        repeat (3) tick();
        check("done_drop_kept", bias_loaded, 1);

        feed(100 - tb_pix, NOSTALL, 0);
        drain();
        check("pix_at_100", tb_pix, 100);
        bias_reload = 1'b1;
        tick();
        bias_reload = 1'b0;
        bias_src = mkbias(3);
        bias_src[15:0] = 16'h0200;
        feed(NP - 100, NOSTALL, 0);
        c = 0;
        while (n_frames == 0 && c < 20) begin
            tick();
            c++;
        end
        check("frame1_seen", n_frames, 1);
        check("frame1_wrap", tb_pix, 0);
        saw_low = 1'b0;
        c = 0;
        while (c < 40) begin
            if (bias_loaded !== 1'b1) saw_low = 1'b1;
            if (saw_low && bias_loaded === 1'b1) break;
            check("reload_block", psum_ready, 0);
            tick();
            c++;
        end
        check("reload_saw_low", saw_low, 1);
        check("reload_loaded", bias_loaded, 1);
        check("reload_req", n_req, 2);
        check("reload_ready", psum_ready, 1);
        bias_model = bias_src;
        p[31:0] = 32'h0001_8000;
        psum = p;
        psum_valid = 1'b1;
        tick();
        psum_valid = 1'b0;
        tick();
        check("newbias_ch0", out_data[15:0], 16'h0380);
        feed(4, NOSTALL, 0);
        drain();

        feed(301 - tb_pix, NOSTALL, 0);
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_loaded", bias_loaded, 0);
        check("mid_rst_ready", psum_ready, 0);
        tick();
        rst = 1'b0;
        done_conv_bias = 1'b1;
        bias_src = mkbias(5);
        bias_model = bias_src;
        wait_loaded("rst_reload_loaded");
        check("rst_reload_req", n_req, 3);
        feed(NP, NOSTALL, 0);
        drain();
        check("frame2_seen", n_frames, 2);
        check("frame2_wrap", tb_pix, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
